acap_bram_mailbox: RTL and testbench
====================================

ACAP_BRAM_MAILBOX -- requirements
Module: acap_bram_mailbox

Interface
REQ-001 Parameter IN_WORDS, default 4096: words copied from in stream to BRAM addresses 0..IN_WORDS-1.
REQ-002 Parameter OUT_WORDS, default 2048: result words read from RESULT_BASE upward.
REQ-003 Parameter POLL_GAP, default 16: idle cycles between successive done-marker polls.
REQ-004 Parameter POLL_LIMIT, default 1000000: max polls before timeout (used only under REQ-027).
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle job request; honoured only in IDLE.
REQ-008 in_valid/in_ready/in_data  in/out/in  1/1/32  input stream, word moves when both high.
REQ-009 out_valid/out_ready/out_data  out/in/out  1/1/32  result stream, same rule.
REQ-010 bram_en, bram_we, bram_addr, bram_wdata  out  1/4/32/32  shared dual-port BRAM port B; bram_we 4'b1111 = full-word write.
REQ-011 bram_rdata  in  32  read data, valid exactly one cycle after bram_en with bram_we=0.
REQ-012 busy, done, timeout_err  out  1/1/1  job active; one-cycle completion pulse; sticky timeout flag.

Function
REQ-013 States: IDLE, LOAD, CLEAR, KICK, POLL_RD, POLL_CHK, GAP, DRAIN_RD, DRAIN_OUT, FINISH.
REQ-014 IDLE->LOAD on start; busy high from next cycle until FINISH exits.
REQ-015 LOAD: in_ready=1; each accepted word written same cycle to bram_addr=count, count 0..IN_WORDS-1; after last word ->CLEAR.
REQ-016 CLEAR: single write of 32'h0 to DONE_ADDR (0x1789), purging stale markers ->KICK.
REQ-017 KICK: single write of START_WORD 32'hdeadbeef to START_ADDR (0x1004) ->POLL_RD.
REQ-018 POLL_RD: read DONE_ADDR ->POLL_CHK; POLL_CHK: bram_rdata==32'hd01ecafe ->DRAIN_RD else ->GAP.
REQ-019 GAP: wait POLL_GAP cycles with bram_en=0 ->POLL_RD.
REQ-020 DRAIN_RD: read RESULT_BASE+idx (0x1800+idx) ->DRAIN_OUT; DRAIN_OUT: out_valid=1, out_data=captured word held stable until out_ready.
REQ-021 On out handshake: idx==OUT_WORDS-1 ->FINISH else idx+1 ->DRAIN_RD; throughput max one word per 2 cycles.
REQ-022 FINISH: done=1 for one cycle ->IDLE; counters zeroed.
REQ-023 bram_en=0, bram_we=0 in every state not listed as accessing BRAM; at most one access per cycle.
REQ-024 start while busy ignored; in_valid outside LOAD ignored (in_ready=0); out_ready with out_valid=0 no effect.
REQ-025 in_valid low in LOAD stalls without writing; address counter never exceeds IN_WORDS-1 (no wrap).

Reset
REQ-026 resetn=0 at any edge, including mid-job: state IDLE, counters 0, all outputs 0 (busy, done, timeout_err, in_ready, out_valid, bram_en, bram_we, bram_addr, bram_wdata, out_data); partial BRAM contents left as is.

Configuration
REQ-027 Macro MAILBOX_TIMEOUT_EN defined: poll counter; reaching POLL_LIMIT failed checks sets timeout_err (sticky until reset or next start) and ->FINISH without drain, done pulses.
REQ-028 Macro undefined: no poll counter, timeout_err tied 0, polling unbounded.

Structure
REQ-029 Package acap_mailbox_pkg holds START_ADDR, DONE_ADDR, RESULT_BASE, START_WORD, DONE_WORD and the state enum typedef.
REQ-030 One sub-module mailbox_poll_timer: GAP countdown plus (under macro) poll-limit counter.

Verification
REQ-031 start, stream 4096 words 0..4095 with in_valid steady -> BRAM[0..4095] match, then 0x1789 written 0, then 0x1004 written 0xdeadbeef, in that order.
REQ-032 Model writes 0xd01ecafe to 0x1789 after 5000 cycles, results 0x1800+i = i*3 -> 2048 words out in order, done pulses once, busy falls.
REQ-033 out_ready toggled 1-of-3 cycles -> out_data stable while out_valid&~out_ready, no word lost or duplicated.
REQ-034 Stale 0xd01ecafe preloaded at 0x1789 before start -> cleared in CLEAR, no drain until model rewrites marker.
REQ-035 MAILBOX_TIMEOUT_EN, POLL_LIMIT=4, marker never written -> exactly 4 polls, timeout_err=1, done pulse, out_valid never high.
REQ-036 resetn low for one cycle mid-DRAIN (idx=100), then new start -> outputs 0 after reset, second job completes from idx 0.

Source files
------------

// File: rtl/acap_mailbox_pkg.sv
// Shared constants and state encoding for the ACAP BRAM mailbox.
// Fixed BRAM map used by the host/AIE side of the mailbox protocol.
package acap_mailbox_pkg;

  localparam logic [31:0] START_ADDR  = 32'h0000_1004;
  localparam logic [31:0] DONE_ADDR   = 32'h0000_1789;
  localparam logic [31:0] RESULT_BASE = 32'h0000_1800;
  localparam logic [31:0] START_WORD  = 32'hdead_beef;
  localparam logic [31:0] DONE_WORD   = 32'hd01e_cafe;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_KICK,
    S_POLL_RD,
    S_POLL_CHK,
    S_GAP,
    S_DRAIN_RD,
    S_DRAIN_OUT,
    S_FINISH
  } mbx_state_e;

endpackage

// File: rtl/mailbox_poll_timer.sv
// Gap countdown between done-marker polls, plus optional poll-limit
// counter built only when MAILBOX_TIMEOUT_EN is defined.
module mailbox_poll_timer #(
  parameter int POLL_GAP   = 16,
  parameter int POLL_LIMIT = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_gap_run,
  input  logic i_poll_fail,
  input  logic i_clear,
  output logic o_gap_done,
  output logic o_last_poll
);

  localparam int GW = $clog2(POLL_GAP + 1);

  logic [GW-1:0] r_gap;

  assign o_gap_done = (r_gap == GW'(POLL_GAP - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_gap <= '0;
    end else if (i_gap_run && !o_gap_done) begin
      r_gap <= r_gap + GW'(1);
    end else begin
      r_gap <= '0;
    end
  end

`ifdef MAILBOX_TIMEOUT_EN
  localparam int LW = $clog2(POLL_LIMIT + 1);

  logic [LW-1:0] r_polls;

  assign o_last_poll = (r_polls == LW'(POLL_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!resetn || i_clear) begin
      r_polls <= '0;
    end else if (i_poll_fail) begin
      r_polls <= r_polls + LW'(1);
    end
  end
`else
  logic w_unused;

  assign w_unused    = i_poll_fail ^ i_clear;
  assign o_last_poll = 1'b0;
`endif

endmodule

// File: rtl/acap_bram_mailbox.sv
// Streams a job into shared BRAM, kicks the consumer, polls for its
// done marker and streams results back. MAILBOX_TIMEOUT_EN bounds polling.
import acap_mailbox_pkg::*;

module acap_bram_mailbox #(
  parameter int IN_WORDS   = 4096,
  parameter int OUT_WORDS  = 2048,
  parameter int POLL_GAP   = 16,
  parameter int POLL_LIMIT = 1000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  input  logic [31:0] bram_rdata,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam int CW = $clog2(IN_WORDS + 1);
  localparam int IW = $clog2(OUT_WORDS + 1);

  mbx_state_e    r_state;
  mbx_state_e    w_nxt;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic          r_first;
  logic [31:0]   r_data;
  logic          w_fail;
  logic          w_gap_done;
  logic          w_last_poll;
  logic          w_kick_job;
  logic          w_in_last;
  logic          w_out_last;

  assign w_kick_job = (r_state == S_IDLE) && start;
  assign w_in_last  = (r_cnt == CW'(IN_WORDS - 1));
  assign w_out_last = (r_idx == IW'(OUT_WORDS - 1));
  assign busy       = (r_state != S_IDLE);
  // The read word is live on bram_rdata for one cycle only, then held.
  assign out_data   = r_first ? bram_rdata : r_data;

  mailbox_poll_timer #(
    .POLL_GAP   (POLL_GAP),
    .POLL_LIMIT (POLL_LIMIT)
  ) u_timer (
    .clk         (clk),
    .resetn      (resetn),
    .i_gap_run   (r_state == S_GAP),
    .i_poll_fail (w_fail),
    .i_clear     (w_kick_job || (r_state == S_FINISH)),
    .o_gap_done  (w_gap_done),
    .o_last_poll (w_last_poll)
  );

  always_comb begin
    w_nxt      = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    bram_en    = 1'b0;
    bram_we    = 4'b0000;
    bram_addr  = 32'h0;
    bram_wdata = 32'h0;
    done       = 1'b0;
    w_fail     = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_nxt = S_LOAD;
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          bram_en    = 1'b1;
          bram_we    = 4'b1111;
          bram_addr  = 32'(r_cnt);
          bram_wdata = in_data;
          if (w_in_last) w_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        bram_en   = 1'b1;
        bram_we   = 4'b1111;
        bram_addr = DONE_ADDR;
        w_nxt     = S_KICK;
      end
      S_KICK: begin
        bram_en    = 1'b1;
        bram_we    = 4'b1111;
        bram_addr  = START_ADDR;
        bram_wdata = START_WORD;
        w_nxt      = S_POLL_RD;
      end
      S_POLL_RD: begin
        bram_en   = 1'b1;
        bram_addr = DONE_ADDR;
        w_nxt     = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        if (bram_rdata == DONE_WORD) begin
          w_nxt = S_DRAIN_RD;
        end else begin
          w_fail = 1'b1;
          w_nxt  = w_last_poll ? S_FINISH : S_GAP;
        end
      end
      S_GAP: if (w_gap_done) w_nxt = S_POLL_RD;
      S_DRAIN_RD: begin
        bram_en   = 1'b1;
        bram_addr = RESULT_BASE + 32'(r_idx);
        w_nxt     = S_DRAIN_OUT;
      end
      S_DRAIN_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_nxt = w_out_last ? S_FINISH : S_DRAIN_RD;
      end
      S_FINISH: begin
        done  = 1'b1;
        w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_first <= 1'b0;
      r_data  <= 32'h0;
    end else begin
      r_state <= w_nxt;
      r_first <= (r_state == S_DRAIN_RD);
      if (r_first) r_data <= bram_rdata;
      if (r_state == S_LOAD && in_valid) begin
        r_cnt <= w_in_last ? '0 : r_cnt + CW'(1);
      end
      if (r_state == S_DRAIN_OUT && out_ready) begin
        r_idx <= w_out_last ? '0 : r_idx + IW'(1);
      end
      if (r_state == S_FINISH) begin
        r_cnt <= '0;
        r_idx <= '0;
      end
    end
  end

`ifdef MAILBOX_TIMEOUT_EN
  logic r_tout;

  assign timeout_err = r_tout;

  always_ff @(posedge clk) begin
    if (!resetn || w_kick_job) begin
      r_tout <= 1'b0;
    end else if (w_fail && w_last_poll) begin
      r_tout <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_acap_bram_mailbox.sv
// Bench for acap_bram_mailbox: BRAM/consumer model, write-order and
// result scoreboards. Define MAILBOX_TIMEOUT_EN to add the timeout job.
module tb_acap_bram_mailbox;
  import acap_mailbox_pkg::*;

  localparam int IN_W  = 4096;
  localparam int OUT_W = 2048;
  localparam int GAP   = 16;
`ifdef MAILBOX_TIMEOUT_EN
  localparam int LIMIT = 4;
  localparam int DLY   = 30;
`else
  localparam int LIMIT = 1000000;
  localparam int DLY   = 5000;
`endif

  logic        clk;
  logic        resetn;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata;
  logic        busy;
  logic        done;
  logic        timeout_err;

  acap_bram_mailbox #(
    .IN_WORDS   (IN_W),
    .OUT_WORDS  (OUT_W),
    .POLL_GAP   (GAP),
    .POLL_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_wdata  (bram_wdata),
    .bram_rdata  (bram_rdata),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] mem [0:8191];
  logic [63:0] wq [$];
  logic [31:0] sb [$];
  bit          mdl_en = 1'b1;
  bit          stale_req = 1'b0;
  bit          mkr_done = 1'b0;
  int          mdl_cnt = 0;
  logic [31:0] res_salt = 32'h0;
  bit          rdy13 = 1'b0;
  int          n_out, n_done, n_early, n_polls, n_ov;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dv(input int k, input int salt);
    return 32'(k) + 32'(salt) * 32'h0100_0000;
  endfunction

  function automatic logic [31:0] rv(input int i, input logic [31:0] salt);
    return 32'(i) * 32'd3 + salt * 32'h0001_0000;
  endfunction

  // BRAM port B plus the consumer that answers a kick after DLY cycles.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we == 4'b1111) mem[bram_addr[12:0]] <= bram_wdata;
      else bram_rdata <= mem[bram_addr[12:0]];
    end
    if (stale_req) mem[DONE_ADDR[12:0]] <= DONE_WORD;
    if (bram_en && bram_we == 4'b1111 && bram_addr == START_ADDR) begin
      mkr_done <= 1'b0;
      if (mdl_en) mdl_cnt <= DLY;
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        for (int i = 0; i < OUT_W; i++)
          mem[13'h1800 + 13'(i)] <= rv(i, res_salt);
        mem[DONE_ADDR[12:0]] <= DONE_WORD;
        mkr_done <= 1'b1;
      end
    end
  end

  always @(posedge mkr_done) begin
    for (int i = 0; i < OUT_W; i++) sb.push_back(rv(i, res_salt));
  end

  initial begin
    int cyc;
    cyc = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      out_ready = rdy13 ? (cyc % 3 == 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (bram_en && bram_we != 4'b0000) begin
      if (wq.size() == 0) begin
        chk("wr_extra", bram_addr, 32'hffff_ffff);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", bram_addr, e[63:32]);
        chk("wr_data", bram_wdata, e[31:0]);
        chk("wr_we", 32'(bram_we), 32'hf);
      end
    end
    if (bram_en && bram_we == 4'b0000 && bram_addr == DONE_ADDR) n_polls++;
    if (out_valid && !mkr_done) n_early++;
    if (out_valid) n_ov++;
    if (done) n_done++;
    if (prev_stall && out_valid) chk("hold", out_data, prev_data);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("out_extra", out_data, 32'hffff_ffff);
      else chk("out_data", out_data, sb.pop_front());
      n_out++;
    end
  end

  task automatic zero_outs();
    chk("z_busy", 32'(busy), 0);
    chk("z_done", 32'(done), 0);
    chk("z_tout", 32'(timeout_err), 0);
    chk("z_in_ready", 32'(in_ready), 0);
    chk("z_out_valid", 32'(out_valid), 0);
    chk("z_bram_en", 32'(bram_en), 0);
    chk("z_bram_we", 32'(bram_we), 0);
    chk("z_bram_addr", bram_addr, 0);
    chk("z_bram_wdata", bram_wdata, 0);
    chk("z_out_data", out_data, 0);
  endtask

  task automatic run_job(input int salt, input bit stall, input bit stale,
                         input int stop_at, input bit tmo);
    int k, guard, nst;
    bit hs;
    if (stale) begin
      @(negedge clk);
      stale_req = 1'b1;
      @(negedge clk);
      stale_req = 1'b0;
    end
    for (int i = 0; i < IN_W; i++) wq.push_back({32'(i), dv(i, salt)});
    wq.push_back({DONE_ADDR, 32'h0});
    wq.push_back({START_ADDR, START_WORD});
    res_salt = 32'(salt);
    n_out = 0; n_done = 0; n_early = 0; n_polls = 0; n_ov = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_up", 32'(busy), 1);
    k = 0; guard = 0; nst = 0;
    while (k < IN_W) begin
      in_data  = dv(k, salt);
      in_valid = !(stall && k == 10 && nst < 5);
      if (!in_valid) nst++;
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) k++;
      guard++;
      if (guard > 3 * IN_W) begin
        chk("load_timeout", 32'(k), 32'(IN_W));
        break;
      end
    end
    in_valid = 1'b0;
    guard = 0;
    while (n_done == 0 && !(stop_at >= 0 && n_out >= stop_at)) begin
      @(posedge clk);
      guard++;
      if (guard > 40000) begin
        chk("job_timeout", 32'(n_out), 32'(OUT_W));
        break;
      end
    end
    if (stop_at < 0) begin
      repeat (3) @(negedge clk);
      chk("n_done", 32'(n_done), 1);
      chk("busy_fall", 32'(busy), 0);
      chk("wq_empty", 32'(wq.size()), 0);
      if (tmo) begin
        chk("n_polls", 32'(n_polls), 32'(LIMIT));
        chk("tout_set", 32'(timeout_err), 1);
        chk("no_out", 32'(n_ov), 0);
      end else begin
        chk("n_out", 32'(n_out), 32'(OUT_W));
        chk("sb_empty", 32'(sb.size()), 0);
        chk("early_out", 32'(n_early), 0);
        chk("tout_clr", 32'(timeout_err), 0);
      end
    end
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    repeat (3) @(negedge clk);
    zero_outs();
    resetn = 1'b1;

    rdy13 = 1'b1;
    run_job(0, 1'b0, 1'b0, -1, 1'b0);
    chk("bram_last_in", mem[IN_W-1], dv(IN_W - 1, 0));
    chk("bram_kick", mem[START_ADDR[12:0]], START_WORD);

    rdy13 = 1'b0;
    run_job(1, 1'b1, 1'b1, -1, 1'b0);

    run_job(2, 1'b0, 1'b0, 100, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    zero_outs();
    resetn = 1'b1;
    sb.delete();
    wq.delete();

    run_job(3, 1'b0, 1'b0, -1, 1'b0);

`ifdef MAILBOX_TIMEOUT_EN
    mdl_en = 1'b0;
    run_job(4, 1'b0, 1'b0, -1, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
